// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared register-file constants and round-robin pointer helper.
package regfile_wb_arbiter_pkg;

   localparam int DATA_W = 64;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_priority_arbiter.sv
// rr_priority_arbiter: combinational round-robin select via rotate, priority-pick, un-rotate.
module rr_priority_arbiter #(
   parameter int N = 2,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);

   logic [N-1:0] rot;
   logic [W-1:0] sel;
   int idx;

   always_comb begin
      rot = '0;
      sel = '0;
      gnt = '0;
      for (int i = 0; i < N; i++) rot[i] = req[W'((i + int'(ptr)) % N)];
      // Descending scan so the lowest rotated position (closest to ptr) wins.
      for (int i = N - 1; i >= 0; i--) if (rot[i]) sel = W'(i);
      idx = (int'(sel) + int'(ptr)) % N;
      gnt_idx = |rot ? W'(idx) : '0;
      for (int i = 0; i < N; i++) gnt[i] = |rot && i == idx;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with a registered
// output stage; write_reg/wb_busy double as the in-flight hazard address.
module regfile_wb_arbiter #(
   parameter int N_REQ = 2,
   parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
   parameter int ADDR_W = regfile_wb_arbiter_pkg::REG_ADDR_W,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*ADDR_W-1:0]  req_addr,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic [ADDR_W-1:0]        write_reg,
   output logic [DATA_W-1:0]        write_data,
   output logic                     reg_write_en,
   output logic                     wb_busy,
   output logic [IDX_W-1:0]         grant_idx
);

   import regfile_wb_arbiter_pkg::*;

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] arb_idx;
   logic [N_REQ-1:0] arb_gnt;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic xfer;

   rr_priority_arbiter #(.N(N_REQ)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(arb_gnt),
      .gnt_idx(arb_idx)
   );

   assign req_ready = (reset || flush) ? '0 : arb_gnt;
   assign xfer = |(req_valid & req_ready);
   assign sel_addr = req_addr[arb_idx*ADDR_W +: ADDR_W];
   assign sel_data = req_data[arb_idx*DATA_W +: DATA_W];
   assign wb_busy = reg_write_en;

   // x0 writes are accepted so the requester drains, but never enable the port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_reg <= '0;
         write_data <= '0;
         reg_write_en <= 1'b0;
         grant_idx <= '0;
         rr_ptr <= '0;
      end else begin
         reg_write_en <= xfer && sel_addr != ADDR_W'(REG_X0);
         if (xfer) begin
            write_reg <= sel_addr;
            write_data <= sel_data;
            grant_idx <= arb_idx;
            rr_ptr <= IDX_W'(rr_next(int'(arb_idx), N_REQ));
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench; a reference round-robin model queues expected
// port writes at drive time, and each task compares ready bits and port outputs inline.
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic en;
      logic [4:0] reg_a;
      logic [63:0] data;
      logic idx;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic [1:0] req_valid = 2'b11;
   logic [1:0] req_ready;
   logic [9:0] req_addr = '0;
   logic [127:0] req_data = '0;
   logic [4:0] write_reg;
   logic [63:0] write_data;
   logic reg_write_en;
   logic wb_busy;
   logic grant_idx;

   wr_t sb[$];
   wr_t exp_w;
   wr_t m_port = '0;
   logic m_ptr = 1'b0;
   logic [1:0] m_ready;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .req_data(req_data),
      .write_reg(write_reg),
      .write_data(write_data),
      .reg_write_en(reg_write_en),
      .wb_busy(wb_busy),
      .grant_idx(grant_idx)
   );

   task automatic drive(input logic [1:0] v, input logic f, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [63:0] d0, input logic [63:0] d1);
      logic g;
      @(negedge clk);
      req_valid = v;
      flush = f;
      req_addr = {a1, a0};
      req_data = {d1, d0};
      m_ready = 2'b00;
      if (!f) begin
         if (v[m_ptr]) m_ready[m_ptr] = 1'b1;
         else if (v[!m_ptr]) m_ready[!m_ptr] = 1'b1;
      end
      m_port.en = 1'b0;
      if (m_ready != 2'b00) begin
         g = m_ready[1];
         m_port.reg_a = g ? a1 : a0;
         m_port.data = g ? d1 : d0;
         m_port.idx = g;
         m_port.en = m_port.reg_a != 5'd0;
         m_ptr = !g;
      end
      sb.push_back(m_port);
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      exp_w = sb.size() > 0 ? sb.pop_front() : '0;
   endtask

   task automatic model_reset();
      m_ptr = 1'b0;
      m_port = '0;
      sb.delete();
   endtask

   task automatic test_reset();
      #7;
      total++;
      if (req_ready !== 2'b00) begin
         bad++;
         $display("FAIL reset_ready: got %b want 00", req_ready);
      end
      total++;
      if ({reg_write_en, wb_busy, write_reg, write_data, grant_idx} !== '0) begin
         bad++;
         $display("FAIL reset_port: got en=%b busy=%b reg=%0d data=%h idx=%0d want all zero",
                  reg_write_en, wb_busy, write_reg, write_data, grant_idx);
      end
      @(negedge clk);
      req_valid = 2'b00;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_both_valid();
      for (int c = 0; c < 4; c++) begin
         drive(2'b11, 1'b0, 5'd1, 5'd2, 64'h100 + 64'(c), 64'h200 + 64'(c));
         total++;
         if (req_ready !== m_ready || req_ready !== (c % 2 == 0 ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL both_ready[%0d]: got %b want %b", c, req_ready, m_ready);
         end
         advance();
         total++;
         if ({reg_write_en, wb_busy, write_reg, write_data, grant_idx} !==
             {exp_w.en, exp_w.en, exp_w.reg_a, exp_w.data, exp_w.idx} || reg_write_en !== 1'b1) begin
            bad++;
            $display("FAIL both_port[%0d]: got en=%b busy=%b reg=%0d data=%h idx=%0d want en=%b reg=%0d data=%h idx=%0d",
                     c, reg_write_en, wb_busy, write_reg, write_data, grant_idx,
                     exp_w.en, exp_w.reg_a, exp_w.data, exp_w.idx);
         end
      end
   endtask

   task automatic test_single();
      drive(2'b01, 1'b0, 5'd3, 5'd0, 64'hDEAD_BEEF, 64'h0);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL single_ready: got %b want 01", req_ready);
      end
      advance();
      total++;
      if ({reg_write_en, wb_busy, write_reg, write_data, grant_idx} !== {1'b1, 1'b1, 5'd3, 64'hDEAD_BEEF, 1'b0}) begin
         bad++;
         $display("FAIL single_port: got en=%b busy=%b reg=%0d data=%h idx=%0d want en=1 reg=3 data=deadbeef idx=0",
                  reg_write_en, wb_busy, write_reg, write_data, grant_idx);
      end
      drive(2'b00, 1'b0, 5'd0, 5'd0, 64'h0, 64'h0);
      total++;
      if (req_ready !== 2'b00) begin
         bad++;
         $display("FAIL idle_ready: got %b want 00", req_ready);
      end
      advance();
      total++;
      if ({reg_write_en, wb_busy, write_reg, write_data} !== {1'b0, 1'b0, 5'd3, 64'hDEAD_BEEF}) begin
         bad++;
         $display("FAIL idle_port: got en=%b busy=%b reg=%0d data=%h want en=0 reg=3 data=deadbeef",
                  reg_write_en, wb_busy, write_reg, write_data);
      end
   endtask

   task automatic test_x0();
      drive(2'b10, 1'b0, 5'd0, 5'd0, 64'h0, 64'h55);
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL x0_ready: got %b want 10", req_ready);
      end
      advance();
      total++;
      if ({reg_write_en, wb_busy, grant_idx} !== {1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL x0_port: got en=%b busy=%b idx=%0d want en=0 busy=0 idx=1",
                  reg_write_en, wb_busy, grant_idx);
      end
   endtask

   task automatic test_same_addr();
      drive(2'b01, 1'b0, 5'd9, 5'd0, 64'h99, 64'h0);
      advance();
      for (int c = 0; c < 2; c++) begin
         drive(c == 0 ? 2'b11 : 2'b01, 1'b0, 5'd7, 5'd7, 64'h1, 64'h2);
         total++;
         if (req_ready !== (c == 0 ? 2'b10 : 2'b01)) begin
            bad++;
            $display("FAIL same_ready[%0d]: got %b want %b", c, req_ready, m_ready);
         end
         advance();
         total++;
         if ({reg_write_en, write_reg, write_data, grant_idx} !==
             {1'b1, 5'd7, (c == 0 ? 64'h2 : 64'h1), (c == 0 ? 1'b1 : 1'b0)} || exp_w.data !== write_data) begin
            bad++;
            $display("FAIL same_port[%0d]: got en=%b reg=%0d data=%h idx=%0d want reg=7 data=%h idx=%0d",
                     c, reg_write_en, write_reg, write_data, grant_idx, exp_w.data, exp_w.idx);
         end
      end
   endtask

   task automatic test_flush();
      drive(2'b11, 1'b1, 5'd4, 5'd5, 64'hA, 64'hB);
      total++;
      if (req_ready !== 2'b00) begin
         bad++;
         $display("FAIL flush_ready: got %b want 00", req_ready);
      end
      advance();
      total++;
      if ({reg_write_en, wb_busy} !== 2'b00) begin
         bad++;
         $display("FAIL flush_port: got en=%b busy=%b want 0 0", reg_write_en, wb_busy);
      end
      drive(2'b11, 1'b0, 5'd4, 5'd5, 64'hA, 64'hB);
      total++;
      if (req_ready !== 2'b10) begin
         bad++;
         $display("FAIL flush_resume_ready: got %b want 10", req_ready);
      end
      advance();
      total++;
      if ({reg_write_en, write_reg, write_data, grant_idx} !== {1'b1, 5'd5, 64'hB, 1'b1}) begin
         bad++;
         $display("FAIL flush_resume_port: got en=%b reg=%0d data=%h idx=%0d want en=1 reg=5 data=b idx=1",
                  reg_write_en, write_reg, write_data, grant_idx);
      end
   endtask

   task automatic test_random();
      logic [1:0] v;
      logic [4:0] a0, a1;
      logic [63:0] d0, d1;
      for (int c = 0; c < 24; c++) begin
         v = 2'($urandom_range(3));
         a0 = 5'($urandom_range(31));
         a1 = 5'($urandom_range(31));
         d0 = {32'($urandom), 32'($urandom)};
         d1 = {32'($urandom), 32'($urandom)};
         drive(v, 1'b0, a0, a1, d0, d1);
         total++;
         if (req_ready !== m_ready) begin
            bad++;
            $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, m_ready);
         end
         advance();
         total++;
         if ({reg_write_en, wb_busy, write_reg, write_data, grant_idx} !==
             {exp_w.en, exp_w.en, exp_w.reg_a, exp_w.data, exp_w.idx}) begin
            bad++;
            $display("FAIL rand_port[%0d]: got en=%b busy=%b reg=%0d data=%h idx=%0d want en=%b reg=%0d data=%h idx=%0d",
                     c, reg_write_en, wb_busy, write_reg, write_data, grant_idx,
                     exp_w.en, exp_w.reg_a, exp_w.data, exp_w.idx);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(2'b10, 1'b0, 5'd0, 5'd6, 64'h0, 64'h66);
      advance();
      total++;
      if ({reg_write_en, write_reg, grant_idx} !== {1'b1, 5'd6, 1'b1}) begin
         bad++;
         $display("FAIL areset_pre: got en=%b reg=%0d idx=%0d want en=1 reg=6 idx=1",
                  reg_write_en, write_reg, grant_idx);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({reg_write_en, wb_busy, write_reg, write_data, grant_idx, req_ready} !== '0) begin
         bad++;
         $display("FAIL areset_port: got en=%b busy=%b reg=%0d data=%h idx=%0d ready=%b want all zero",
                  reg_write_en, wb_busy, write_reg, write_data, grant_idx, req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      reset = 1'b0;
      model_reset();
      drive(2'b11, 1'b0, 5'd8, 5'd9, 64'h8, 64'h9);
      total++;
      if (req_ready !== 2'b01) begin
         bad++;
         $display("FAIL areset_prio: got %b want 01", req_ready);
      end
      advance();
      total++;
      if ({reg_write_en, write_reg, write_data, grant_idx} !== {1'b1, 5'd8, 64'h8, 1'b0}) begin
         bad++;
         $display("FAIL areset_after: got en=%b reg=%0d data=%h idx=%0d want en=1 reg=8 data=8 idx=0",
                  reg_write_en, write_reg, write_data, grant_idx);
      end
   endtask

   initial begin
      test_reset();
      test_both_valid();
      test_single();
      test_x0();
      test_same_addr();
      test_flush();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
